layer_sequencer: RTL and testbench
==================================

Name: layer_sequencer

Overview:
- Parametrised network-level sequencer that steps an inference through NUM_LAYERS layers in order.
- For each layer it streams input addresses 0..len-1 with valid/ready backpressure, asserts that layer's one-hot run strobe, and waits for the layer's done.
- Adds per-run length configuration, done-timeout, early-done detection, abort and error reporting.
- Sits between the top-level start/ready interface and the per-layer neuron arrays and their shared input memory.

Parameters:
- NUM_LAYERS, 3, number of layers sequenced (1..16).
- ADDR_W, 10, width of the address and per-layer length fields.
- IDX_W, 2, width of layer_idx; must be at least clog2(NUM_LAYERS), and 1 minimum.
- TIMEOUT, 4096, maximum cycles in WAIT_DONE before a timeout error; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  run request; sampled only in IDLE and ERROR.
- abort  in  1  synchronous abort, honoured in any state.
- layer_len  in  NUM_LAYERS*ADDR_W  per-layer input count; layer k occupies bits [k*ADDR_W +: ADDR_W].
- layer_done  in  NUM_LAYERS  per-layer completion pulse or level.
- addr_ready  in  1  consumer accepts the current address.
- addr  out  ADDR_W  current input address.
- addr_valid  out  1  addr is valid.
- addr_last  out  1  current beat is len-1 of the active layer.
- layer_run  out  NUM_LAYERS  one-hot run strobe for the active layer.
- layer_idx  out  IDX_W  active layer index.
- busy  out  1  high in RUN, WAIT_DONE and DONE.
- network_ready  out  1  one-cycle pulse when a run completes.
- error  out  1  sticky error flag.
- err_code  out  2  error cause: 01 timeout, 10 early done, 11 zero length.

Behaviour:
- Reset (async assert) drives all outputs to 0 and state to IDLE. The length snapshot and timeout counter are cleared.
- States: IDLE, RUN, WAIT_DONE, DONE, ERROR. All outputs are registered.
- IDLE, or ERROR, with start=1:
  - Snapshot layer_len into an internal register; later changes to layer_len have no effect until the next start.
  - Clear error and err_code.
  - If any snapshot length is 0: go to ERROR with err_code=11.
  - Otherwise, at the next edge: state=RUN, layer_idx=0, addr=0, addr_valid=1, layer_run=one-hot(0).
  - Latency from start sampled to the first addr_valid is 1 cycle.
- RUN:
  - A beat transfers when addr_valid && addr_ready.
  - On a transfer with addr < len-1: addr increments.
  - When addr_ready=0: addr, addr_valid and addr_last hold.
  - addr_last is high exactly while addr == len-1.
  - On the transfer of the last beat: addr_valid=0, addr and addr_last return to 0, state=WAIT_DONE, timeout counter=0. layer_run stays asserted.
  - layer_done[layer_idx]=1 seen in RUN before the last beat transfers: go to ERROR with err_code=10.
  - layer_done bits of non-active layers are ignored in every state.
- WAIT_DONE:
  - The timeout counter increments each cycle.
  - On layer_done[layer_idx]=1:
    - If this is not the final layer: layer_idx+1, addr=0, addr_valid=1, layer_run shifts to the next bit in the same edge, and state returns to RUN. There are no bubble cycles between layers.
    - If this is the final layer: layer_run=0, state=DONE.
  - When the counter reaches TIMEOUT-1 without done (TIMEOUT>0): go to ERROR with err_code=01.
  - If done and timeout occur in the same cycle, done wins.
- DONE: network_ready=1 for exactly one cycle, then IDLE. busy is high in DONE and low in IDLE.
- ERROR:
  - error=1, and layer_run, addr_valid and busy are all 0.
  - The state holds until start (which restarts the run as described for IDLE) or reset.
- abort=1 in any state: at the next edge, state=IDLE, and layer_run, addr, addr_valid, addr_last, busy and network_ready are all 0. error and err_code are unchanged. abort has priority over start and done in the same cycle.
- start while busy is ignored.
- A length of 1 gives a single beat with addr=0 and addr_last=1 together.
- Lengths are unsigned; the maximum legal length is 2^ADDR_W - 1.
- The address never wraps past len-1.

Test Plan:
1. NUM_LAYERS=3, lengths 784/128/32, addr_ready=1, each done pulsed 3 cycles after its last beat.
   - Addresses 0..783, 0..127 and 0..31 are each contiguous, with addr_last on 783, 127 and 31.
   - layer_run goes 001→010→100.
   - network_ready pulses once, 1 cycle after done[2]; busy then drops.
2. Length 5, addr_ready toggling 1,0,0,1,…
   - Exactly 5 transfers with addresses 0..4 and no duplicates.
   - addr holds while ready is low.
3. TIMEOUT=16, done never asserted after the last beat of layer 0.
   - error=1 and err_code=01 exactly 16 cycles after entering WAIT_DONE.
   - layer_run=0.
   - A subsequent start clears error and restarts from layer 0.
4. layer_done[0] asserted at beat 10 of a 784-beat layer.
   - ERROR with err_code=10; addr_valid=0 the next cycle.
   - Pulsing layer_done[1] during layer 0 has no effect.
5. abort at beat 50 of layer 1.
   - Next cycle: IDLE, all outputs 0, no network_ready.
   - Asserting start together with abort is ignored.
6. Config with layer_len[1]=0 → ERROR with err_code=11, no addr_valid. Async rst asserted mid-RUN → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : layer_sequencer
// Brief    : Steps an inference through NUM_LAYERS layers, streaming input
//            addresses per layer and handshaking each layer's done.
// Revision : 1.0 - initial release
// ============================================================================
module layer_sequencer #(
    parameter int NUM_LAYERS = 3,
    parameter int ADDR_W     = 10,
    parameter int IDX_W      = 2,
    parameter int TIMEOUT    = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic [NUM_LAYERS*ADDR_W-1:0] layer_len,
    input  logic [NUM_LAYERS-1:0]        layer_done,
    input  logic                         addr_ready,
    output logic [ADDR_W-1:0]            addr,
    output logic                         addr_valid,
    output logic                         addr_last,
    output logic [NUM_LAYERS-1:0]        layer_run,
    output logic [IDX_W-1:0]             layer_idx,
    output logic                         busy,
    output logic                         network_ready,
    output logic                         error,
    output logic [1:0]                   err_code
);

    localparam int                    TMO_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0]      TMO_LAST    = (TIMEOUT > 0) ? TMO_W'(TIMEOUT - 1) : '0;
    localparam logic [NUM_LAYERS-1:0] RUN_FIRST   = NUM_LAYERS'(1);
    localparam logic [IDX_W-1:0]      IDX_FINAL   = IDX_W'(NUM_LAYERS - 1);
    localparam logic [1:0]            ERR_TIMEOUT = 2'b01;
    localparam logic [1:0]            ERR_EARLY   = 2'b10;
    localparam logic [1:0]            ERR_ZERO    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RUN       = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_DONE      = 3'd3,
        S_ERROR     = 3'd4
    } state_t;

    state_t                         state_q, state_d;
    logic [NUM_LAYERS*ADDR_W-1:0]   len_q, len_d;
    logic [TMO_W-1:0]               tmo_q, tmo_d;
    logic [ADDR_W-1:0]              addr_q, addr_d;
    logic                           addr_valid_q, addr_valid_d;
    logic                           addr_last_q, addr_last_d;
    logic [NUM_LAYERS-1:0]          layer_run_q, layer_run_d;
    logic [IDX_W-1:0]               layer_idx_q, layer_idx_d;
    logic                           busy_q, busy_d;
    logic                           network_ready_q, network_ready_d;
    logic                           error_q, error_d;
    logic [1:0]                     err_code_q, err_code_d;

    logic [IDX_W-1:0]               next_idx;
    logic [ADDR_W-1:0]              cur_len;
    logic [ADDR_W-1:0]              next_len;
    logic                           cur_done;
    logic                           len_has_zero;
    logic                           beat;
    logic                           go_err;
    logic [1:0]                     err_cause;

    assign next_idx = layer_idx_q + IDX_W'(1);
    assign beat     = addr_valid_q && addr_ready;

    // Select the active/next layer's length and done; other layers' done bits never reach the FSM.
    always_comb begin
        cur_len      = '0;
        next_len     = '0;
        cur_done     = 1'b0;
        len_has_zero = 1'b0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (layer_idx_q == IDX_W'(k)) begin
                cur_len  = len_q[k*ADDR_W +: ADDR_W];
                cur_done = layer_done[k];
            end
            if (next_idx == IDX_W'(k)) begin
                next_len = len_q[k*ADDR_W +: ADDR_W];
            end
            if (layer_len[k*ADDR_W +: ADDR_W] == '0) begin
                len_has_zero = 1'b1;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        len_d           = len_q;
        tmo_d           = tmo_q;
        addr_d          = addr_q;
        addr_valid_d    = addr_valid_q;
        addr_last_d     = addr_last_q;
        layer_run_d     = layer_run_q;
        layer_idx_d     = layer_idx_q;
        busy_d          = busy_q;
        network_ready_d = 1'b0;
        error_d         = error_q;
        err_code_d      = err_code_q;
        go_err          = 1'b0;
        err_cause       = 2'b00;

        if (abort) begin
            state_d      = S_IDLE;
            tmo_d        = '0;
            addr_d       = '0;
            addr_valid_d = 1'b0;
            addr_last_d  = 1'b0;
            layer_run_d  = '0;
            layer_idx_d  = '0;
            busy_d       = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_ERROR: begin
                    if (start) begin
                        len_d      = layer_len;
                        error_d    = 1'b0;
                        err_code_d = 2'b00;
                        if (len_has_zero) begin
                            go_err    = 1'b1;
                            err_cause = ERR_ZERO;
                        end else begin
                            state_d      = S_RUN;
                            layer_idx_d  = '0;
                            addr_d       = '0;
                            addr_valid_d = 1'b1;
                            addr_last_d  = (layer_len[ADDR_W-1:0] == ADDR_W'(1));
                            layer_run_d  = RUN_FIRST;
                            busy_d       = 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    // A done arriving with the final beat is treated as on time.
                    if (beat && addr_last_q) begin
                        state_d      = S_WAIT_DONE;
                        tmo_d        = '0;
                        addr_d       = '0;
                        addr_valid_d = 1'b0;
                        addr_last_d  = 1'b0;
                    end else if (cur_done) begin
                        go_err    = 1'b1;
                        err_cause = ERR_EARLY;
                    end else if (beat) begin
                        addr_d      = addr_q + ADDR_W'(1);
                        addr_last_d = ((addr_q + ADDR_W'(1)) == (cur_len - ADDR_W'(1)));
                    end
                end
                S_WAIT_DONE: begin
                    if (cur_done) begin
                        if (layer_idx_q == IDX_FINAL) begin
                            state_d         = S_DONE;
                            layer_run_d     = '0;
                            network_ready_d = 1'b1;
                        end else begin
                            state_d      = S_RUN;
                            layer_idx_d  = next_idx;
                            addr_d       = '0;
                            addr_valid_d = 1'b1;
                            addr_last_d  = (next_len == ADDR_W'(1));
                            layer_run_d  = layer_run_q << 1;
                        end
                    end else if ((TIMEOUT > 0) && (tmo_q == TMO_LAST)) begin
                        go_err    = 1'b1;
                        err_cause = ERR_TIMEOUT;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            if (go_err) begin
                state_d      = S_ERROR;
                error_d      = 1'b1;
                err_code_d   = err_cause;
                addr_d       = '0;
                addr_valid_d = 1'b0;
                addr_last_d  = 1'b0;
                layer_run_d  = '0;
                layer_idx_d  = '0;
                busy_d       = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            len_q           <= '0;
            tmo_q           <= '0;
            addr_q          <= '0;
            addr_valid_q    <= 1'b0;
            addr_last_q     <= 1'b0;
            layer_run_q     <= '0;
            layer_idx_q     <= '0;
            busy_q          <= 1'b0;
            network_ready_q <= 1'b0;
            error_q         <= 1'b0;
            err_code_q      <= 2'b00;
        end else begin
            state_q         <= state_d;
            len_q           <= len_d;
            tmo_q           <= tmo_d;
            addr_q          <= addr_d;
            addr_valid_q    <= addr_valid_d;
            addr_last_q     <= addr_last_d;
            layer_run_q     <= layer_run_d;
            layer_idx_q     <= layer_idx_d;
            busy_q          <= busy_d;
            network_ready_q <= network_ready_d;
            error_q         <= error_d;
            err_code_q      <= err_code_d;
        end
    end

    assign addr          = addr_q;
    assign addr_valid    = addr_valid_q;
    assign addr_last     = addr_last_q;
    assign layer_run     = layer_run_q;
    assign layer_idx     = layer_idx_q;
    assign busy          = busy_q;
    assign network_ready = network_ready_q;
    assign error         = error_q;
    assign err_code      = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_sequencer
// Brief    : Self-checking bench for layer_sequencer (beat scoreboard + tables).
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer_sequencer;

    localparam int NL       = 3;
    localparam int AW       = 10;
    localparam int IW       = 2;
    localparam int TMO      = 16;
    localparam int DONE_DLY = 3;

    typedef struct {
        int         l0;
        int         l1;
        int         l2;
        bit         mode;
        bit         exp_err;
        logic [1:0] exp_code;
    } cfg_t;

    typedef struct {
        logic [IW-1:0] idx;
        logic [NL-1:0] run;
        logic          last;
        logic [AW-1:0] addr;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [NL*AW-1:0] layer_len = '0;
    logic [NL-1:0]    layer_done = '0;
    logic             addr_ready = 1'b0;
    logic [AW-1:0]    addr;
    logic             addr_valid;
    logic             addr_last;
    logic [NL-1:0]    layer_run;
    logic [IW-1:0]    layer_idx;
    logic             busy;
    logic             network_ready;
    logic             error;
    logic [1:0]       err_code;

    int      n_checks = 0;
    int      n_fail   = 0;
    int      nr_seen  = 0;
    bit      mon_en   = 1'b0;
    bit      prev_stall = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    beat_t   exp_q[$];
    beat_t   mon_b;
    cfg_t    tbl[5];

    layer_sequencer #(
        .NUM_LAYERS(NL),
        .ADDR_W    (AW),
        .IDX_W     (IW),
        .TIMEOUT   (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .layer_len    (layer_len),
        .layer_done   (layer_done),
        .addr_ready   (addr_ready),
        .addr         (addr),
        .addr_valid   (addr_valid),
        .addr_last    (addr_last),
        .layer_run    (layer_run),
        .layer_idx    (layer_idx),
        .busy         (busy),
        .network_ready(network_ready),
        .error        (error),
        .err_code     (err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [NL*AW-1:0] pack(input int a, input int b, input int c);
        return {AW'(c), AW'(b), AW'(a)};
    endfunction

    task automatic push_layer(input int k, input int len, input int n);
        beat_t b;
        for (int a = 0; a < n; a++) begin
            b.idx  = IW'(k);
            b.run  = NL'(1) << k;
            b.last = (a == len - 1);
            b.addr = AW'(a);
            exp_q.push_back(b);
        end
    endtask

    // Beat scoreboard plus hold check while the consumer stalls.
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall)
                check("addr_hold", {21'd0, addr_valid, addr}, {21'd0, 1'b1, prev_addr});
            if (addr_valid && addr_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got addr %0d, expected no transfer", addr);
                end else begin
                    mon_b = exp_q.pop_front();
                    check("beat", {16'd0, layer_idx, layer_run, addr_last, addr},
                          {16'd0, mon_b.idx, mon_b.run, mon_b.last, mon_b.addr});
                end
            end
            prev_stall = addr_valid && !addr_ready;
            prev_addr  = addr;
        end else begin
            prev_stall = 1'b0;
        end
        if (network_ready) nr_seen++;
    end

    task automatic run_cfg(input cfg_t c);
        int   lens[3];
        int   cd, cur, cyc, done2_cyc, nr_cyc, nr_start;
        bit   fin;
        logic seen;
        lens      = '{c.l0, c.l1, c.l2};
        layer_len = pack(c.l0, c.l1, c.l2);
        if (!c.exp_err)
            for (int k = 0; k < NL; k++) push_layer(k, lens[k], lens[k]);
        nr_start  = nr_seen;
        cd = -1; cur = 0; cyc = 0; done2_cyc = -100; nr_cyc = -1; fin = 0;
        @(posedge clk); #1; start = 1'b1; layer_done = '0;
        @(posedge clk); #1; start = 1'b0; addr_ready = 1'b1;
        @(negedge clk);
        if (c.exp_err) begin
            check("zero_len_err", {27'd0, error, err_code, busy, addr_valid},
                  {27'd0, 1'b1, c.exp_code, 1'b0, 1'b0});
            seen = 1'b0;
            repeat (3) begin
                @(negedge clk);
                seen = seen | addr_valid;
            end
            check("zero_len_no_valid", {31'd0, seen}, 32'd0);
            return;
        end
        check("first_beat", {12'd0, addr_valid, addr, layer_run, layer_idx, busy, error, err_code},
              {12'd0, 1'b1, 10'd0, 3'b001, 2'd0, 1'b1, 1'b0, 2'b00});
        if (addr_valid && addr_ready && addr_last) cd = DONE_DLY - 1;
        while (!fin && cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
            layer_done = '0;
            if (cd == 0) begin
                layer_done[cur] = 1'b1;
                if (cur == NL - 1) done2_cyc = cyc;
                cur++;
                cd = -1;
            end else if (cd > 0) begin
                cd--;
            end
            addr_ready = c.mode ? (cyc % 3 == 0) : 1'b1;
            @(negedge clk);
            if (addr_valid && addr_ready && addr_last) cd = DONE_DLY - 1;
            if (network_ready) begin
                fin    = 1'b1;
                nr_cyc = cyc;
            end
        end
        check("run_complete", {31'd0, fin}, 32'd1);
        check("nr_latency", nr_cyc, done2_cyc + 1);
        check("queue_empty", exp_q.size(), 0);
        @(posedge clk); #1; layer_done = '0;
        @(negedge clk);
        check("idle_after_run", {26'd0, busy, network_ready, addr_valid, layer_run},
              {26'd0, 1'b0, 1'b0, 1'b0, 3'b000});
        check("nr_once", nr_seen - nr_start, 1);
    endtask

    initial begin
        int   a;
        int   cd, cur;
        bit   found, got_err, done_ab;
        logic [IW-1:0] obs_idx;
        logic [AW-1:0] obs_addr;
        int   nr_before;

        tbl[0] = '{l0: 784,  l1: 128, l2: 32, mode: 1'b0, exp_err: 1'b0, exp_code: 2'b00};
        tbl[1] = '{l0: 5,    l1: 3,   l2: 1,  mode: 1'b1, exp_err: 1'b0, exp_code: 2'b00};
        tbl[2] = '{l0: 1,    l1: 1,   l2: 1,  mode: 1'b0, exp_err: 1'b0, exp_code: 2'b00};
        tbl[3] = '{l0: 10,   l1: 0,   l2: 7,  mode: 1'b0, exp_err: 1'b1, exp_code: 2'b11};
        tbl[4] = '{l0: 1023, l1: 2,   l2: 1,  mode: 1'b1, exp_err: 1'b0, exp_code: 2'b00};

        repeat (3) @(negedge clk);
        check("reset_state", {10'd0, addr, addr_valid, addr_last, layer_run, layer_idx, busy,
              network_ready, error, err_code}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 5; i++) run_cfg(tbl[i]);

        // Timeout after the last beat of layer 0, then a clean restart.
        layer_len = pack(4, 4, 4);
        push_layer(0, 4, 4);
        @(posedge clk); #1; start = 1'b1; addr_ready = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (addr_valid && addr_ready && addr_last) found = 1'b1;
        end
        check("tmo_last_beat", {31'd0, found}, 32'd1);
        @(posedge clk);
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("tmo_not_yet", {28'd0, error, layer_run}, {28'd0, 1'b0, 3'b001});
        @(posedge clk);
        @(negedge clk);
        check("tmo_error", {24'd0, error, err_code, layer_run, addr_valid, busy},
              {24'd0, 1'b1, 2'b01, 3'b000, 1'b0, 1'b0});
        check("tmo_queue_empty", exp_q.size(), 0);
        run_cfg('{l0: 3, l1: 2, l2: 1, mode: 1'b0, exp_err: 1'b0, exp_code: 2'b00});

        // Early done on layer 0; done of layer 1 meanwhile is ignored.
        layer_len = pack(784, 128, 32);
        push_layer(0, 784, 12);
        @(posedge clk); #1; start = 1'b1; addr_ready = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        got_err = 1'b0;
        for (int i = 0; i < 100 && !got_err; i++) begin
            @(negedge clk);
            if (error) begin
                got_err = 1'b1;
            end else begin
                a = int'(addr);
                if (a == 8)
                    check("ignore_other_done", {27'd0, addr_valid, error, layer_run},
                          {27'd0, 1'b1, 1'b0, 3'b001});
                @(posedge clk); #1;
                layer_done = '0;
                if (a == 5)  layer_done[1] = 1'b1;
                if (a == 10) layer_done[0] = 1'b1;
            end
        end
        layer_done = '0;
        check("early_done_err", {26'd0, got_err, err_code, addr_valid, layer_run[1:0]},
              {26'd0, 1'b1, 2'b10, 1'b0, 2'b00});
        check("early_queue_empty", exp_q.size(), 0);

        // Abort (with start) at beat 50 of layer 1.
        layer_len = pack(100, 100, 100);
        push_layer(0, 100, 100);
        push_layer(1, 100, 52);
        nr_before = nr_seen;
        @(posedge clk); #1; start = 1'b1; addr_ready = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        cd = -1; cur = 0; done_ab = 1'b0;
        for (int i = 0; i < 400 && !done_ab; i++) begin
            @(negedge clk);
            if (addr_valid && addr_ready && addr_last) cd = DONE_DLY - 1;
            obs_idx  = layer_idx;
            obs_addr = addr;
            @(posedge clk); #1;
            layer_done = '0;
            if (cd == 0) begin
                layer_done[cur] = 1'b1;
                cur++;
                cd = -1;
            end else if (cd > 0) begin
                cd--;
            end
            if (obs_idx == 2'd1 && obs_addr == 10'd50) begin
                abort   = 1'b1;
                start   = 1'b1;
                done_ab = 1'b1;
            end
        end
        check("abort_reached", {31'd0, done_ab}, 32'd1);
        @(negedge clk);
        @(posedge clk); #1; abort = 1'b0; start = 1'b0;
        @(negedge clk);
        check("abort_outputs", {10'd0, addr, addr_valid, addr_last, layer_run, layer_idx, busy,
              network_ready, error, err_code}, 32'd0);
        repeat (3) @(negedge clk);
        check("abort_stays_idle", {29'd0, busy, addr_valid, network_ready}, 32'd0);
        check("abort_no_nr", nr_seen - nr_before, 0);
        check("abort_queue_empty", exp_q.size(), 0);

        // Asynchronous reset in the middle of a run.
        layer_len = pack(50, 50, 50);
        push_layer(0, 50, 50);
        @(posedge clk); #1; start = 1'b1; addr_ready = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (20) @(negedge clk);
        check("pre_reset_running", {30'd0, busy, addr_valid}, 32'd3);
        mon_en = 1'b0;
        exp_q.delete();
        #2 rst = 1'b1;
        #1;
        check("async_reset", {10'd0, addr, addr_valid, addr_last, layer_run, layer_idx, busy,
              network_ready, error, err_code}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("post_reset_idle", {29'd0, busy, addr_valid, error}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
